// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback sources.
// Optional RF_ARB_ZERO_DROP_EN: address-0 requests are accepted and dropped without using a grant slot.
module regfile_write_arbiter #(
    parameter int WORD_SIZE     = 64,
    parameter int REG_ADDR_SIZE = 4,
    parameter int NUM_REQ       = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             hold,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*REG_ADDR_SIZE-1:0] req_addr,
    input  logic [NUM_REQ*WORD_SIZE-1:0]     req_data,
    output logic [REG_ADDR_SIZE-1:0]         rf_write,
    output logic [WORD_SIZE-1:0]             rf_data,
    output logic                             wb_valid,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id
);
    localparam int ID_W = $clog2(NUM_REQ);

    // Handshake: a transfer happens in any cycle where req_valid[i] && req_ready[i];
    // req_ready may depend on req_valid, never the reverse.

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    ptr_next;
    logic               grant_any;
    logic [NUM_REQ-1:0] zero_addr;
    logic [NUM_REQ-1:0] eligible;
    int                 scan_idx;

    always_comb begin
        zero_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            zero_addr[i] = (req_addr[i*REG_ADDR_SIZE +: REG_ADDR_SIZE] == '0);
        end
    end

`ifdef RF_ARB_ZERO_DROP_EN
    assign eligible = req_valid & ~zero_addr & {NUM_REQ{~hold}};
`else
    assign eligible = req_valid & {NUM_REQ{~hold}};
`endif

    // First eligible index found scanning upward from ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(ptr) + k) % NUM_REQ;
            if (!grant_any && eligible[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
`ifdef RF_ARB_ZERO_DROP_EN
        req_ready = req_ready | (req_valid & zero_addr);
`endif
    end

    assign ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write <= '0;
            rf_data  <= '0;
            wb_valid <= 1'b0;
            grant_id <= '0;
            ptr      <= '0;
        end else if (grant_any) begin
            rf_write <= req_addr[int'(grant_idx)*REG_ADDR_SIZE +: REG_ADDR_SIZE];
            rf_data  <= req_data[int'(grant_idx)*WORD_SIZE +: WORD_SIZE];
            wb_valid <= 1'b1;
            grant_id <= grant_idx;
            ptr      <= ptr_next;
        end else begin
            // Idle writes target register 0, which is hardwired to zero.
            rf_write <= '0;
            rf_data  <= '0;
            wb_valid <= 1'b0;
        end
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Round-robin arbiter that shares the single write port of the dual-read register file between NUM_REQ writeback sources (ALU, load unit, etc.). Each source uses a valid/ready handshake. The arbiter grants at most one write per cycle and drives the register file write address and data from registered outputs. Idle cycles drive write address 0, which is a no-op because register 0 is hardwired to zero.

Parameters:
- WORD_SIZE, 64, width of each register and of write data
- REG_ADDR_SIZE, 4, register address width; the file holds 1<<REG_ADDR_SIZE entries
- NUM_REQ, 2, number of requesters; must be >= 2
- ID_W (localparam), $clog2(NUM_REQ), width of the grant index

Ports:
- clk  in  1  clock; all state updates on the posedge
- rst_n  in  1  asynchronous, active-low reset
- hold  in  1  stall; when 1, no grants are issued
- req_valid  in  NUM_REQ  bit i: requester i has a write pending
- req_ready  out  NUM_REQ  bit i: requester i's write is accepted this cycle (combinational)
- req_addr  in  NUM_REQ*REG_ADDR_SIZE  requester i address at [i*REG_ADDR_SIZE +: REG_ADDR_SIZE]
- req_data  in  NUM_REQ*WORD_SIZE  requester i data at [i*WORD_SIZE +: WORD_SIZE]
- rf_write  out  REG_ADDR_SIZE  write address to the register file (registered)
- rf_data  out  WORD_SIZE  write data to the register file (registered)
- wb_valid  out  1  rf_write/rf_data carry a granted write this cycle (registered)
- grant_id  out  ID_W  index of the requester owning the current rf_write/rf_data (registered)

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - rf_write=0, rf_data=0, wb_valid=0, grant_id=0, round-robin pointer ptr=0.
  - Any in-flight write is discarded.
- req_ready is combinational and may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- A transfer occurs in cycle t when req_valid[i] and req_ready[i] are both 1. The requester may change its addr/data in cycle t+1.
- Arbitration, when hold=0:
  - Scan indices ptr, ptr+1, ... modulo NUM_REQ. The first index with req_valid=1 wins.
  - Only the winner's req_ready bit is 1; all other bits are 0.
  - No valid requests: req_ready=0 everywhere.
- Output update at the edge ending cycle t:
  - Grant to requester i: rf_write<=addr_i, rf_data<=data_i, wb_valid<=1, grant_id<=i, ptr<=(i+1) mod NUM_REQ.
  - No grant: rf_write<=0, rf_data<=0, wb_valid<=0. grant_id and ptr hold their values.
- Latency: the handshake occurs in cycle t, the write is presented in cycle t+1, and the register file commits it at the edge ending t+1.
- hold=1: req_ready=0 for all requesters, outputs update as in the no-grant case, and ptr holds. When hold deasserts, the scan resumes from the held ptr.
- Fairness: under continuous requests from all requesters, each one is granted exactly once every NUM_REQ cycles.
- Wrap-around: ptr moves from NUM_REQ-1 to 0.
- Same-address writes from different requesters are serialized in grant order; the last grant wins in the register file.
- Address-0 requests are granted like any other and produce a harmless write to register 0 (behaviour changes with the optional feature below).

Optional Feature:
- Macro: RF_ARB_ZERO_DROP_EN
- Defined:
  - Every requester with req_valid=1 and addr=0 gets req_ready=1 in the same cycle, regardless of hold or arbitration. Its request is dropped.
  - Arbitration considers only requests with addr != 0.
  - wb_valid is not asserted for dropped requests.
  - ptr advances only on a nonzero-address grant.
- Undefined: addr=0 requests consume a normal grant slot. They produce rf_write=0 with wb_valid=1.

Test Plan:
- Reset: assert rst_n=0 between clock edges -> rf_write=0, rf_data=0, wb_valid=0, grant_id=0 immediately. Then release, drive req_valid=2'b01 -> requester 0 is granted first.
- Single write: req_valid=2'b10, addr1=5, data1=0xDEAD -> req_ready=2'b10 the same cycle. Next cycle rf_write=5, rf_data=0xDEAD, wb_valid=1, grant_id=1. The cycle after, rf_write=0, wb_valid=0.
- Contention: NUM_REQ=2, both requesters valid for 6 cycles -> grant_id sequence 0,1,0,1,0,1 and req_ready alternates 01,10,...
- Stall: hold=1 for 3 cycles with both valid, ptr=1 -> req_ready=0 and wb_valid=0 throughout. When hold=0, requester 1 is granted first.
- Zero address: req0 addr=0, req1 addr=3, both valid, ptr=0.
  - Without the macro: requester 0 is granted, rf_write=0, wb_valid=1; requester 1 follows next cycle.
  - With the macro: req_ready=2'b11, rf_write=3, grant_id=1, ptr=0.
- Reset mid-operation: grant requester 0 (addr=7), then pull rst_n low before the next edge -> rf_write=0 and wb_valid=0 immediately, and no write to register 7 occurs.
